// File: rtl/oled_pixel_streamer_if.sv
// Pixel-generator / SPI-pin bundle between the OLED streamer and its peers.
// master = streamer side; slave = generator/panel side.
interface oled_pixel_streamer_if;
    logic        enable;
    logic [15:0] oled_data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        sclk;
    logic        sdin;
    logic        cs_n;
    logic        dc;
    logic        frame_begin;
    logic        busy;

    modport master (
        input  enable,
        input  oled_data,
        output x,
        output y,
        output sclk,
        output sdin,
        output cs_n,
        output dc,
        output frame_begin,
        output busy
    );

    modport slave (
        output enable,
        output oled_data,
        input  x,
        input  y,
        input  sclk,
        input  sdin,
        input  cs_n,
        input  dc,
        input  frame_begin,
        input  busy
    );
endinterface

// File: rtl/oled_pixel_streamer.sv
// Raster scanner + SPI serialiser for a 96x64 RGB565 OLED panel.
// Asks generators for x/y colour, shifts the word out MSB first.
module oled_pixel_streamer #(
    parameter int WIDTH   = 96,
    parameter int HEIGHT  = 64,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    oled_pixel_streamer_if.master bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] SHIFT   = 2'd2;
    localparam logic [1:0] ADVANCE = 2'd3;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
    localparam logic [5:0] Y_LAST = 6'(HEIGHT - 1);

    logic [1:0]    state;
    logic [DW-1:0] div;
    logic [3:0]    bit_cnt;
    logic [15:0]   shreg;
    logic [6:0]    x;
    logic [5:0]    y;
    logic          sclk;
    logic          cs_n;

    logic phase_end;
    logic last_bit;

    assign phase_end = (div == DIV_LAST);
    assign last_bit  = (bit_cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= 4'd15;
            shreg   <= '0;
            x       <= '0;
            y       <= '0;
            sclk    <= 1'b1;
            cs_n    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.enable)
                        state <= FETCH;
                end
                FETCH: begin
                    shreg   <= bus.oled_data;
                    cs_n    <= 1'b0;
                    sclk    <= 1'b0;
                    div     <= '0;
                    bit_cnt <= 4'd15;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (!phase_end) begin
                        div <= div + DW'(1);
                    end else begin
                        div <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (last_bit) begin
                            // sclk stays high: it is also the idle level
                            cs_n  <= 1'b1;
                            state <= ADVANCE;
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt - 4'd1;
                            shreg   <= {shreg[14:0], 1'b0};
                        end
                    end
                end
                ADVANCE: begin
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST)
                            y <= '0;
                        else
                            y <= y + 6'd1;
                    end else begin
                        x <= x + 7'd1;
                    end
                    state <= bus.enable ? FETCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x           = x;
    assign bus.y           = y;
    assign bus.sclk        = sclk;
    assign bus.sdin        = shreg[15];
    assign bus.cs_n        = cs_n;
    assign bus.dc          = 1'b1;
    assign bus.frame_begin = (state == FETCH) && (x == '0) && (y == '0);
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer: default instance plus a small 8x4,
// CLK_DIV=1 instance; SPI words decoded and compared with a raster model.
`timescale 1ns/1ps
module tb_oled_pixel_streamer;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        int          low;
        longint      gap;
        longint      fall;
        int          pmin;
        int          pmax;
    } rec_t;

    typedef struct {
        logic [15:0] src;
        logic [15:0] exp_word;
        int          exp_low;
        int          exp_gap;
        int          exp_per;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, en0, en1;
    int          mode [2];
    logic [15:0] cval [2];
    logic [15:0] key  [2];

    oled_pixel_streamer_if bus0();
    oled_pixel_streamer_if bus1();

    function automatic logic [15:0] gen(int m, logic [15:0] c,
        logic [15:0] k, logic [6:0] px, logic [5:0] py);
        logic [15:0] t;
        t = {1'b0, px, 2'b00, py};
        if (m == 0) return c;
        if (m == 1) return t;
        return (t * 16'd40503) ^ k;
    endfunction

    assign bus0.enable    = en0;
    assign bus1.enable    = en1;
    assign bus0.oled_data = gen(mode[0], cval[0], key[0], bus0.x, bus0.y);
    assign bus1.oled_data = gen(mode[1], cval[1], key[1], bus1.x, bus1.y);

    oled_pixel_streamer dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (bus0)
    );

    oled_pixel_streamer #(.WIDTH(8), .HEIGHT(4), .CLK_DIV(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    // ---------------- SPI monitor (decodes the pins) ----------------
    logic       sck [2], csn [2], sdi [2], fbg [2], dcs [2];
    logic [6:0] xs [2];
    logic [5:0] ys [2];
    assign sck[0] = bus0.sclk;  assign sck[1] = bus1.sclk;
    assign csn[0] = bus0.cs_n;  assign csn[1] = bus1.cs_n;
    assign sdi[0] = bus0.sdin;  assign sdi[1] = bus1.sdin;
    assign fbg[0] = bus0.frame_begin; assign fbg[1] = bus1.frame_begin;
    assign dcs[0] = bus0.dc;    assign dcs[1] = bus1.dc;
    assign xs[0]  = bus0.x;     assign xs[1]  = bus1.x;
    assign ys[0]  = bus0.y;     assign ys[1]  = bus1.y;

    rec_t   wq0 [$], wq1 [$];
    longint fbq0 [$], fbq1 [$];
    int     fbn1 [$];
    longint cyc;
    int     hi_chg [2], dc_bad [2], range_bad [2], nw [2];

    initial begin
        logic        psck [2], pcsn [2], psdi [2];
        logic [15:0] acc [2];
        int          nb [2], lowc [2], pmn [2], pmx [2];
        longint      lrise [2], lfall [2], gapv [2];
        rec_t        r;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            psck[i] = 1'b1; pcsn[i] = 1'b1; psdi[i] = 1'b0;
            acc[i] = '0; nb[i] = 0; lowc[i] = 0; pmn[i] = 0; pmx[i] = 0;
            lrise[i] = -1; lfall[i] = -1; gapv[i] = 0;
            hi_chg[i] = 0; dc_bad[i] = 0; range_bad[i] = 0; nw[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (pcsn[i] && !csn[i]) begin
                    gapv[i] = (lfall[i] >= 0) ? cyc - lfall[i] : 0;
                    lfall[i] = cyc;
                    lowc[i] = 0; nb[i] = 0; acc[i] = '0;
                    pmn[i] = 1000000000; pmx[i] = 0; lrise[i] = -1;
                end
                if (!csn[i]) begin
                    lowc[i]++;
                    if (dcs[i] !== 1'b1) dc_bad[i]++;
                    if (!pcsn[i] && psck[i] && sck[i] && psdi[i] !== sdi[i])
                        hi_chg[i]++;
                    if (sck[i] && !psck[i]) begin
                        acc[i] = {acc[i][14:0], sdi[i]};
                        nb[i]++;
                        if (lrise[i] >= 0) begin
                            if (int'(cyc - lrise[i]) < pmn[i]) pmn[i] = int'(cyc - lrise[i]);
                            if (int'(cyc - lrise[i]) > pmx[i]) pmx[i] = int'(cyc - lrise[i]);
                        end
                        lrise[i] = cyc;
                    end
                end
                if (!pcsn[i] && csn[i]) begin
                    r.word = acc[i]; r.nbits = nb[i]; r.low = lowc[i];
                    r.gap = gapv[i]; r.fall = lfall[i];
                    r.pmin = pmn[i]; r.pmax = pmx[i];
                    nw[i]++;
                    if (i == 0) wq0.push_back(r);
                    else wq1.push_back(r);
                end
                if (fbg[i] === 1'b1) begin
                    if (i == 0) fbq0.push_back(cyc);
                    else begin
                        fbq1.push_back(cyc);
                        fbn1.push_back(nw[i]);
                    end
                end
                if (xs[i] >= (i == 0 ? 7'd96 : 7'd8)) range_bad[i]++;
                if (ys[i] >= (i == 0 ? 6'd63 : 6'd3) && ys[i] != (i == 0 ? 6'd63 : 6'd3))
                    range_bad[i]++;
                psck[i] = sck[i]; pcsn[i] = csn[i]; psdi[i] = sdi[i];
            end
        end
    end

    // ---------------- raster reference model ----------------
    int   checks = 0, errors = 0;
    int   pidx [2], popped [2], seq_bad [2];
    rec_t last [2];

    function automatic logic [15:0] expw(int i, int idx);
        int w, h;
        w = (i == 0) ? 96 : 8;
        h = (i == 0) ? 64 : 4;
        return gen(mode[i], cval[i], key[i], 7'(idx % w), 6'((idx / w) % h));
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic drain(input int i);
        rec_t r;
        while ((i == 0 ? wq0.size() : wq1.size()) > 0) begin
            if (i == 0) r = wq0.pop_front();
            else r = wq1.pop_front();
            if (r.nbits != 16 || r.word !== expw(i, pidx[i])) seq_bad[i]++;
            pidx[i]++;
            popped[i]++;
            last[i] = r;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drain(0);
            drain(1);
        end
    endtask

    task automatic next_word(input int i, input int budget);
        int n0, c;
        n0 = popped[i];
        c = 0;
        while (popped[i] == n0 && c < budget) begin
            tick(1);
            c++;
        end
        chk($sformatf("word_arrival_dut%0d", i), popped[i] > n0, 1);
    endtask

    task automatic wait_shift0(input logic [6:0] tx, input logic [5:0] ty);
        int c;
        c = 0;
        while (!(bus0.x == tx && bus0.y == ty && bus0.cs_n == 1'b0) && c < 20000) begin
            tick(1);
            c++;
        end
        chk($sformatf("reach_%0d_%0d", tx, ty), c < 20000, 1);
    endtask

    vec_t tab [6];

    initial begin
        int   c, idle_bad, nrand;
        longint f0;
        tab[0] = '{16'hF800, 16'hF800, 64, 66, 4};
        tab[1] = '{16'h0001, 16'h0001, 64, 66, 4};
        tab[2] = '{16'h8000, 16'h8000, 64, 66, 4};
        tab[3] = '{16'hFFFF, 16'hFFFF, 64, 66, 4};
        tab[4] = '{16'h0000, 16'h0000, 64, 66, 4};
        tab[5] = '{16'hA5C3, 16'hA5C3, 64, 66, 4};
        for (int i = 0; i < 2; i++) begin
            pidx[i] = 0; popped[i] = 0; seq_bad[i] = 0;
            mode[i] = 0; key[i] = '0;
        end
        cval[0] = tab[0].src;
        cval[1] = 16'hAAAA;
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", bus0.cs_n, 1);
        chk("rst_sclk", bus0.sclk, 1);
        chk("rst_sdin", bus0.sdin, 0);
        chk("rst_dc", bus0.dc, 1);
        chk("rst_frame_begin", bus0.frame_begin, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_x", bus0.x, 0);
        chk("rst_y", bus0.y, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick(3);
        chk("idle_busy", bus0.busy, 0);
        chk("idle_cs_n", bus0.cs_n, 1);

        // table of constant colours on the default instance
        en0 = 1'b1;
        tick(1);
        chk("fetch_busy", bus0.busy, 1);
        chk("fetch_frame_begin", bus0.frame_begin, 1);
        f0 = 0;
        for (int i = 0; i < 6; i++) begin
            next_word(0, 200);
            if (i == 0) f0 = last[0].fall;
            chk($sformatf("tab%0d_word", i), last[0].word, tab[i].exp_word);
            chk($sformatf("tab%0d_cs_low", i), last[0].low, tab[i].exp_low);
            chk($sformatf("tab%0d_sclk_min", i), last[0].pmin, tab[i].exp_per);
            chk($sformatf("tab%0d_sclk_max", i), last[0].pmax, tab[i].exp_per);
            if (i > 0) chk($sformatf("tab%0d_gap", i), last[0].gap, tab[i].exp_gap);
            if (i < 5) cval[0] = tab[i + 1].src;
        end
        chk("fb_count", fbq0.size(), 1);
        chk("fb_to_cs_fall", f0 - (fbq0.size() > 0 ? fbq0[0] : 0), 1);
        chk("x_after_6", bus0.x, 6);

        // coordinate source; drop enable mid-word at (5,2)
        mode[0] = 1;
        wait_shift0(7'd5, 6'd2);
        tick(10);
        en0 = 1'b0;
        c = 0;
        while (bus0.busy && c < 200) begin
            tick(1);
            c++;
        end
        chk("drop_busy", bus0.busy, 0);
        chk("drop_x", bus0.x, 6);
        chk("drop_y", bus0.y, 2);
        chk("drop_last_word", last[0].word, 16'h0502);
        chk("drop_pidx", pidx[0], 198);
        c = popped[0];
        tick(20);
        chk("idle_no_words", popped[0] - c, 0);
        chk("idle_cs_held", bus0.cs_n, 1);
        en0 = 1'b1;
        tick(1);
        chk("resume_fetch", bus0.busy, 1);
        next_word(0, 200);
        chk("resume_word", last[0].word, 16'h0602);

        // asynchronous reset mid-word at (40,2)
        wait_shift0(7'd40, 6'd2);
        tick(5);
        rst0 = 1'b1;
        #1;
        chk("arst_cs_n", bus0.cs_n, 1);
        chk("arst_sclk", bus0.sclk, 1);
        chk("arst_x", bus0.x, 0);
        chk("arst_y", bus0.y, 0);
        chk("arst_busy", bus0.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0;
        wq0.delete();
        fbq0.delete();
        pidx[0] = 0;
        next_word(0, 200);
        chk("post_rst_word", last[0].word, 16'h0000);
        chk("post_rst_fb", fbq0.size(), 1);
        chk("post_rst_fb_to_cs", last[0].fall - (fbq0.size() > 0 ? fbq0[0] : 0), 1);
        next_word(0, 200);
        chk("post_rst_word2", last[0].word, 16'h0100);
        en0 = 1'b0;
        chk("seq_dut0", seq_bad[0], 0);
        chk("sdin_hi_dut0", hi_chg[0], 0);

        // small instance: CLK_DIV=1 alternating pattern
        en1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_word(1, 100);
            chk($sformatf("aaaa%0d_word", i), last[1].word, 16'hAAAA);
            chk($sformatf("aaaa%0d_cs_low", i), last[1].low, 32);
            chk($sformatf("aaaa%0d_sclk_per", i), last[1].pmax, 2);
            chk($sformatf("aaaa%0d_sclk_min", i), last[1].pmin, 2);
            if (i > 0) chk($sformatf("aaaa%0d_gap", i), last[1].gap, 34);
        end
        mode[1] = 1;
        fbq1.delete();
        fbn1.delete();
        c = 0;
        while (fbq1.size() < 2 && c < 3000) begin
            tick(1);
            c++;
        end
        chk("frame_pulses", fbq1.size() >= 2, 1);
        if (fbq1.size() >= 2) begin
            chk("frame_period", fbq1[1] - fbq1[0], 1088);
            chk("frame_words", fbn1[1] - fbn1[0], 32);
        end
        chk("sdin_hi_dut1", hi_chg[1], 0);

        // random enable pattern with hashed colours
        next_word(1, 100);
        mode[1] = 2;
        key[1] = 16'($urandom);
        idle_bad = 0;
        nrand = popped[1];
        for (int it = 0; it < 100; it++) begin
            int hold;
            en1 = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 70);
            tick(hold);
            if (!en1 && hold >= 40 && bus1.busy) idle_bad++;
        end
        en1 = 1'b1;
        next_word(1, 200);
        next_word(1, 200);
        en1 = 1'b0;
        chk("rand_words_seen", (popped[1] - nrand) >= 10, 1);
        chk("rand_idle", idle_bad, 0);
        chk("seq_dut1", seq_bad[1], 0);
        chk("range_dut0", range_bad[0], 0);
        chk("range_dut1", range_bad[1], 0);
        chk("dc_dut0", dc_bad[0], 0);
        chk("dc_dut1", dc_bad[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/oled_pixel_streamer.md
# oled_pixel_streamer

Drives pixels to the 96x64 SSD1331-class OLED over a write-only SPI link. It scans the screen in raster order and presents each coordinate on `x`/`y` to the combinational screen generators (title, menus, game). It registers the returned 16-bit RGB565 `oled_data` and serialises it MSB-first on `sdin`/`sclk`. It is the consumer end of the x/y→`oled_data` interface: the generators answer, this block asks and transmits.

## Interface
- `WIDTH`, 96: pixels per row; `x` wraps at `WIDTH-1`.
- `HEIGHT`, 64: rows per frame; `y` wraps at `HEIGHT-1`.
- `CLK_DIV`, 2: `clk` cycles per `sclk` half-period; must be ≥1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `enable`  in  1  level; streaming permitted while high.
- `oled_data`  in  16  RGB565 colour for the current `x`/`y`, combinational from the generator.
- `x`  out  7  current pixel column, 0..`WIDTH-1`.
- `y`  out  6  current pixel row, 0..`HEIGHT-1`.
- `sclk`  out  1  SPI clock; idles high; panel samples on rising edge.
- `sdin`  out  1  SPI data, MSB first.
- `cs_n`  out  1  chip select, low only while a pixel word is shifting.
- `dc`  out  1  data/command; constant 1 (pixel data) while `cs_n` low.
- `frame_begin`  out  1  one-cycle pulse when pixel (0,0) is fetched.
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, FETCH, SHIFT, ADVANCE.
- IDLE: `cs_n`=1, `sclk`=1. Go to FETCH when `enable`=1.
- FETCH (1 cycle): `x`/`y` have been stable for at least this cycle. Capture `oled_data` into the 16-bit shift register. Pulse `frame_begin` if `x`=0 and `y`=0. Go to SHIFT.
- SHIFT, entry: `cs_n`=0, `dc`=1, `sdin`=bit 15.
- SHIFT, per bit:
  - `sclk` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `sdin` changes only at the start of each low phase and is stable across the rising edge.
  - After the 16th high phase, go to ADVANCE.
- ADVANCE (1 cycle): `cs_n`=1.
  - `x`+1. If `x`=`WIDTH-1`: `x`=0 and `y`+1. If also `y`=`HEIGHT-1`: `y`=0.
  - Then FETCH if `enable`=1, else IDLE.
- `enable` falling mid-pixel: the current 16 bits complete; the block stops in IDLE after ADVANCE.
- Coordinates are retained across IDLE. Streaming resumes at the next pixel, not at (0,0).
- `enable` rising in IDLE: FETCH on the next cycle.
- Arithmetic:
  - Bit counter is 4 bits, 15→0.
  - Divider counts 0..`CLK_DIV-1`.
  - `x`/`y` never exceed `WIDTH-1`/`HEIGHT-1`; no out-of-range value is ever presented.
- Panel initialisation commands are out of scope. `dc` is never driven 0 by this block.

## Timing
- Reset values, applied asynchronously: state=IDLE, `x`=0, `y`=0, `sclk`=1, `sdin`=0, `cs_n`=1, `dc`=1, `frame_begin`=0, `busy`=0, shift register=0.
- Reset mid-SHIFT aborts the word immediately. On release, the next pixel sent is (0,0) with `frame_begin`.
- Cycles per pixel = 2 + 32·`CLK_DIV`. That is 66 at `CLK_DIV`=2; `cs_n` is low for 64 of them.
- Frame period = `WIDTH`·`HEIGHT`·(2+32·`CLK_DIV`) = 405504 cycles at defaults with `enable` held high.
- Generator latency budget: `oled_data` must settle within one `clk` after an `x`/`y` change. `x`/`y` change only in ADVANCE, and the capture happens in the following FETCH.
- `frame_begin` is high in exactly one cycle per frame, the FETCH of (0,0).

## Test plan
- Source = constant 16'hF800, defaults, `enable`=1 after reset:
  - Bits sampled on `sclk` rising edges while `cs_n`=0 read 1111100000000000.
  - `cs_n` is low exactly 64 cycles per pixel.
  - Consecutive `cs_n` falls are 66 cycles apart.
- Source = {x,y} packed as 16'h{1'b0,x,2'b0,y} (x in bits [14:8], y in bits [5:0]), full frame:
  - Decoded words run (0,0),(1,0)…(95,0),(0,1)…(95,63),(0,0).
  - Exactly 6144 words between `frame_begin` pulses.
  - Pulses are 405504 cycles apart.
- Drop `enable` 10 cycles into the SHIFT of pixel (5,2):
  - The word completes; `busy`→0 after ADVANCE; `x`=6, `y`=2.
  - Re-raise `enable`: the next transmitted word is for (6,2).
- Assert `reset` for 3 cycles mid-SHIFT of pixel (40,30):
  - Same cycle: `cs_n`=1, `sclk`=1, `x`=`y`=0.
  - After release: `frame_begin` pulses on the first FETCH and the word for (0,0) is sent.
- `CLK_DIV`=1, source 16'hAAAA:
  - `sclk` period is 2 cycles and `sdin` alternates 1,0.
  - `sdin` never changes while `sclk` is high.
  - Pixel period is 34 cycles.
